lfo_delay_modulator: RTL and testbench
======================================

Name: lfo_delay_modulator

Overview:
- Generates the signed, sample-synchronous delay offset that drives the extra-delay input of the chorus/flanger delay buffer.
- Closes the loop with the delay buffer. Each buffer completion strobe (new delayed sample out) advances a triangle LFO by one sample step. It then computes the next offset with a sequential shift-add multiplier.
- The offset is held stable for the whole next buffer write/read cycle.

Parameters:
- ACC_WIDTH, 24, phase accumulator width in bits; must be >= 18.
- OUT_WIDTH, 14, width of the signed offset output; matches the buffer address width.
- DEPTH_LIMIT, 8191, maximum usable depth in samples; depth_i is clamped to this value.

Ports:
- clk  in  1  system clock (CLK_DSP).
- rst_n  in  1  synchronous, active-low reset.
- sampleDone_i  in  1  one-cycle strobe from the delay buffer (its delayed-sample-valid output).
- enable_i  in  1  1 = LFO runs; 0 = offset forced to 0.
- rate_i  in  ACC_WIDTH  unsigned phase increment per sample.
- depth_i  in  14  unsigned peak offset in samples.
- extraDelay_reg_o  out  OUT_WIDTH signed  offset to the delay buffer.
- extraDelayChanged_reg_o  out  1  one-cycle strobe: new offset valid.
- overrun_reg_o  out  1  sticky: sampleDone_i arrived while busy.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, phase=0, extraDelay_reg_o=0, extraDelayChanged_reg_o=0, overrun_reg_o=0. Reset wins over every other event, including mid-computation; any in-flight result is discarded and no strobe is issued.
- States:
  - IDLE: waits for sampleDone_i.
  - LOAD: 1 cycle.
  - MULT: exactly 14 cycles.
  - UPDATE: 1 cycle.
  - Any illegal encoding goes to IDLE.
- IDLE with sampleDone_i=1 and enable_i=1:
  - phase <= phase + rate_i, modulo 2^ACC_WIDTH (wraps silently).
  - depth <= min(depth_i, DEPTH_LIMIT), latched.
  - Go to LOAD.
- IDLE with sampleDone_i=1 and enable_i=0:
  - phase <= 0, extraDelay_reg_o <= 0, extraDelayChanged_reg_o <= 1 for one cycle.
  - Stay in IDLE.
- LOAD:
  - p = phase[ACC_WIDTH-1 -: 17].
  - u = p[16] ? ~p[15:0] : p[15:0].
  - T = u - 32768, signed 17-bit, range -32768..32767.
  - acc <= 0, bit index i <= 0.
- MULT, one depth bit per cycle for i = 0..13: if depth[i], acc <= acc + (T <<< i). acc is signed, at least 32 bits wide, with no overflow.
- UPDATE:
  - extraDelay_reg_o <= acc >>> 15 (arithmetic shift, floor), truncated to OUT_WIDTH.
  - The result always lies in [-depth, depth-1]; with DEPTH_LIMIT it fits 14-bit signed without saturation.
  - extraDelayChanged_reg_o <= 1 for one cycle.
  - Return to IDLE.
- Latency: the new offset and its strobe are visible after the 16th rising edge following the edge that sampled sampleDone_i. The busy window is 16 cycles, far below the sample period.
- extraDelay_reg_o changes only in UPDATE, on the enable_i=0 path, or on reset. It is otherwise held.
- sampleDone_i while not in IDLE:
  - The strobe is ignored: no phase step, no restart.
  - overrun_reg_o <= 1 and stays set until reset.
- rate_i and enable_i are sampled only in IDLE when sampleDone_i is high. depth_i is sampled only on the same edge when enable_i=1. Changes at any other time have no effect on the current computation.
- rate_i=0 freezes the phase; the output is recomputed and re-strobed every sample.
- depth_i=0 gives output 0 for every phase.
- extraDelayChanged_reg_o is never high for two consecutive cycles.

Test Plan:
- Reset, then depth_i=100, rate_i=0, enable_i=1, one sampleDone_i pulse → phase stays 0, T=-32768, extraDelay_reg_o=-100. Strobe seen exactly 16 edges after the pulse edge, one cycle wide.
- depth_i=100, rate_i=4194304 (2^22), four pulses spaced 100 cycles apart → outputs 0, 99, -1, -100. The fourth pulse shows phase wrap.
- depth_i=16383, rate_i=0, one pulse → depth clamped to 8191, output -8191.
- Second sampleDone_i 5 cycles after the first → ignored: output and strobe timing are those of the first pulse only, and overrun_reg_o=1 stays high until reset.
- rst_n low for 1 cycle during MULT (cycle 8 of computation) → the following cycle shows extraDelay_reg_o=0, overrun_reg_o=0, no strobe. The next pulse restarts from phase 0.
- After a nonzero output, enable_i=0 with a pulse → output 0 and strobe on the next edge. Re-enable with rate_i=0, depth_i=50 and one pulse → -50, confirming phase was reset to 0.

Source files
------------

// File: rtl/lfo_delay_modulator.sv
// lfo_delay_modulator
//   Triangle LFO that produces the signed extra-delay offset for the
//   chorus/flanger delay buffer. Each buffer completion strobe advances the
//   phase by rate_i. The next offset is then computed as T * depth / 32768
//   by a 14-cycle shift-add multiplier. The offset is held between updates.
//
// Ports
//   clk                      system clock
//   rst_n                    synchronous active-low reset
//   sampleDone_i             one-cycle strobe from the delay buffer
//   enable_i                 1 = LFO runs, 0 = offset forced to zero
//   rate_i     [ACC_WIDTH]   unsigned phase increment per sample
//   depth_i    [14]          unsigned peak offset in samples (clamped)
//   extraDelay_reg_o         signed offset to the delay buffer
//   extraDelayChanged_reg_o  one-cycle strobe, new offset valid
//   overrun_reg_o            sticky, sampleDone_i arrived while busy
module lfo_delay_modulator #(
  parameter int ACC_WIDTH   = 24,
  parameter int OUT_WIDTH   = 14,
  parameter int DEPTH_LIMIT = 8191
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sampleDone_i,
  input  logic                        enable_i,
  input  logic [ACC_WIDTH-1:0]        rate_i,
  input  logic [13:0]                 depth_i,
  output logic signed [OUT_WIDTH-1:0] extraDelay_reg_o,
  output logic                        extraDelayChanged_reg_o,
  output logic                        overrun_reg_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_MULT   = 2'd2;
  localparam logic [1:0] S_UPDATE = 2'd3;

  localparam logic [13:0] LIMIT = 14'(DEPTH_LIMIT);

  logic [1:0]                 r_state;
  logic [ACC_WIDTH-1:0]       r_phase;
  logic [13:0]                r_depth;
  logic signed [16:0]         r_t;
  logic signed [31:0]         r_acc;
  logic [3:0]                 r_bit;
  logic signed [OUT_WIDTH-1:0] r_out;
  logic                       r_chg;
  logic                       r_ovr;

  logic [13:0]        w_depth_clamped;
  logic [16:0]        w_p;
  logic [15:0]        w_u;
  logic signed [16:0] w_t;
  logic signed [31:0] w_addend;

  always_comb begin
    w_depth_clamped = (depth_i > LIMIT) ? LIMIT : depth_i;
    // Top 17 phase bits: the MSB selects the falling half, which mirrors
    // the ramp so the result is a symmetric triangle centred on zero.
    w_p = r_phase[ACC_WIDTH-1 -: 17];
    w_u = w_p[16] ? ~w_p[15:0] : w_p[15:0];
    w_t = $signed({1'b0, w_u} - 17'd32768);
    w_addend = r_depth[r_bit] ? ($signed({{15{r_t[16]}}, r_t}) <<< r_bit) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_phase <= '0;
      r_depth <= '0;
      r_t     <= '0;
      r_acc   <= '0;
      r_bit   <= '0;
      r_out   <= '0;
      r_chg   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_chg <= 1'b0;
      if (sampleDone_i && (r_state != S_IDLE))
        r_ovr <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (sampleDone_i) begin
            if (enable_i) begin
              r_phase <= r_phase + rate_i;
              r_depth <= w_depth_clamped;
              r_state <= S_LOAD;
            end else begin
              r_phase <= '0;
              r_out   <= '0;
              r_chg   <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          r_t     <= w_t;
          r_acc   <= '0;
          r_bit   <= '0;
          r_state <= S_MULT;
        end
        S_MULT: begin
          r_acc <= r_acc + w_addend;
          r_bit <= r_bit + 4'd1;
          if (r_bit == 4'd13)
            r_state <= S_UPDATE;
        end
        S_UPDATE: begin
          // Slice of acc starting at bit 15 is the floor of acc / 2^15.
          r_out   <= r_acc[OUT_WIDTH+14:15];
          r_chg   <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign extraDelay_reg_o        = r_out;
  assign extraDelayChanged_reg_o = r_chg;
  assign overrun_reg_o           = r_ovr;

endmodule

// File: tb/tb_lfo_delay_modulator.sv
module tb_lfo_delay_modulator;
  localparam int AW = 24;
  localparam int OW = 14;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 sampleDone_i;
  logic                 enable_i;
  logic [AW-1:0]        rate_i;
  logic [13:0]          depth_i;
  logic signed [OW-1:0] extraDelay_reg_o;
  logic                 extraDelayChanged_reg_o;
  logic                 overrun_reg_o;

  int n_pass  = 0;
  int n_total = 0;
  longint m_phase = 0;

  always #5 clk = ~clk;

  lfo_delay_modulator #(.ACC_WIDTH(AW), .OUT_WIDTH(OW), .DEPTH_LIMIT(8191)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .sampleDone_i            (sampleDone_i),
    .enable_i                (enable_i),
    .rate_i                  (rate_i),
    .depth_i                 (depth_i),
    .extraDelay_reg_o        (extraDelay_reg_o),
    .extraDelayChanged_reg_o (extraDelayChanged_reg_o),
    .overrun_reg_o           (overrun_reg_o)
  );

  // Reference: triangle value from the phase, scaled by depth, floored.
  function automatic int model_out(input longint phase, input int depth);
    longint p, u, t, prod, q;
    int d;
    d = (depth > 8191) ? 8191 : depth;
    p = phase / 128;
    u = (p >= 65536) ? (131071 - p) : p;
    t = u - 32768;
    prod = t * d;
    q = prod / 32768;
    if (prod < 0 && (prod % 32768) != 0) q = q - 1;
    return int'(q);
  endfunction

  function automatic void model_step(input bit en, input longint rate);
    if (en) m_phase = (m_phase + rate) % 64'd16777216;
    else    m_phase = 0;
  endfunction

  // Drives one sampleDone_i pulse, scrambles inputs afterwards, and measures
  // the number of edges after the sampling edge until the strobe appears.
  task automatic run_sample(input bit en, input logic [AW-1:0] rate, input logic [13:0] depth,
                            output int lat, output int val, output bit wide_ok);
    @(negedge clk);
    enable_i = en; rate_i = rate; depth_i = depth; sampleDone_i = 1'b1;
    @(negedge clk);
    sampleDone_i = 1'b0;
    enable_i = 1'($urandom); rate_i = AW'($urandom); depth_i = 14'($urandom);
    lat = -1; val = 0; wide_ok = 1'b0;
    for (int n = 0; n <= 40; n++) begin
      if (n > 0) @(negedge clk);
      if (extraDelayChanged_reg_o) begin
        lat = n;
        break;
      end
    end
    val = int'(extraDelay_reg_o);
    @(negedge clk);
    wide_ok = !extraDelayChanged_reg_o;
    enable_i = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sampleDone_i = 1'b0; enable_i = 1'b0; rate_i = '0; depth_i = '0;
    idle_cycles(3);
    rst_n = 1'b1;
    m_phase = 0;
    @(negedge clk);
    n_total++; if (extraDelay_reg_o !== 14'sd0) $display("FAIL reset_out got %0d exp 0", extraDelay_reg_o); else n_pass++;
    n_total++; if (extraDelayChanged_reg_o !== 1'b0) $display("FAIL reset_chg got %b exp 0", extraDelayChanged_reg_o); else n_pass++;
    n_total++; if (overrun_reg_o !== 1'b0) $display("FAIL reset_ovr got %b exp 0", overrun_reg_o); else n_pass++;
  endtask

  task automatic test_basic;
    int lat, val; bit w;
    run_sample(1'b1, '0, 14'd100, lat, val, w);
    model_step(1'b1, 0);
    n_total++; if (lat !== 16) $display("FAIL basic_latency got %0d exp 16", lat); else n_pass++;
    n_total++; if (val !== -100) $display("FAIL basic_val got %0d exp -100", val); else n_pass++;
    n_total++; if (w !== 1'b1) $display("FAIL basic_strobe_width got %b exp 1", w); else n_pass++;
    idle_cycles(5);
    n_total++; if (int'(extraDelay_reg_o) !== -100) $display("FAIL basic_hold got %0d exp -100", extraDelay_reg_o); else n_pass++;
  endtask

  task automatic test_sequence;
    int lat, val, exp_v; bit w;
    int expv[4] = '{0, 99, -1, -100};
    for (int k = 0; k < 4; k++) begin
      run_sample(1'b1, 24'd4194304, 14'd100, lat, val, w);
      model_step(1'b1, 4194304);
      exp_v = model_out(m_phase, 100);
      n_total++; if (val !== expv[k] || val !== exp_v) $display("FAIL seq_val[%0d] got %0d exp %0d", k, val, expv[k]); else n_pass++;
      n_total++; if (lat !== 16) $display("FAIL seq_latency[%0d] got %0d exp 16", k, lat); else n_pass++;
      idle_cycles(80);
    end
  endtask

  task automatic test_clamp;
    int lat, val; bit w;
    run_sample(1'b1, '0, 14'd16383, lat, val, w);
    model_step(1'b1, 0);
    n_total++; if (val !== -8191) $display("FAIL clamp_val got %0d exp -8191", val); else n_pass++;
    run_sample(1'b1, '0, 14'd0, lat, val, w);
    n_total++; if (val !== 0) $display("FAIL depth0_val got %0d exp 0", val); else n_pass++;
  endtask

  task automatic test_overrun;
    int lat, val, exp_v;
    n_total++; if (overrun_reg_o !== 1'b0) $display("FAIL ovr_pre got %b exp 0", overrun_reg_o); else n_pass++;
    @(negedge clk);
    enable_i = 1'b1; rate_i = 24'd4194304; depth_i = 14'd100; sampleDone_i = 1'b1;
    @(negedge clk);
    sampleDone_i = 1'b0;
    model_step(1'b1, 4194304);
    exp_v = model_out(m_phase, 100);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 4) begin sampleDone_i = 1'b1; rate_i = 24'd1234567; depth_i = 14'd3000; end
      if (n == 5) sampleDone_i = 1'b0;
      if (extraDelayChanged_reg_o) begin lat = n; break; end
    end
    val = int'(extraDelay_reg_o);
    n_total++; if (lat !== 16) $display("FAIL ovr_latency got %0d exp 16", lat); else n_pass++;
    n_total++; if (val !== exp_v) $display("FAIL ovr_val got %0d exp %0d", val, exp_v); else n_pass++;
    n_total++; if (overrun_reg_o !== 1'b1) $display("FAIL ovr_set got %b exp 1", overrun_reg_o); else n_pass++;
    idle_cycles(30);
    n_total++; if (overrun_reg_o !== 1'b1) $display("FAIL ovr_sticky got %b exp 1", overrun_reg_o); else n_pass++;
  endtask

  task automatic test_reset_midcalc;
    int lat, val, seen; bit w;
    @(negedge clk);
    enable_i = 1'b1; rate_i = 24'd4194304; depth_i = 14'd500; sampleDone_i = 1'b1;
    @(negedge clk);
    sampleDone_i = 1'b0;
    idle_cycles(7);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_phase = 0;
    n_total++; if (extraDelay_reg_o !== 14'sd0) $display("FAIL midrst_out got %0d exp 0", extraDelay_reg_o); else n_pass++;
    n_total++; if (overrun_reg_o !== 1'b0) $display("FAIL midrst_ovr got %b exp 0", overrun_reg_o); else n_pass++;
    seen = 0;
    for (int n = 0; n < 30; n++) begin
      if (extraDelayChanged_reg_o) seen++;
      @(negedge clk);
    end
    n_total++; if (seen !== 0) $display("FAIL midrst_nostrobe got %0d exp 0", seen); else n_pass++;
    run_sample(1'b1, '0, 14'd100, lat, val, w);
    model_step(1'b1, 0);
    n_total++; if (val !== -100) $display("FAIL midrst_restart got %0d exp -100", val); else n_pass++;
  endtask

  task automatic test_disable;
    int lat, val; bit w;
    run_sample(1'b1, 24'd8388608, 14'd200, lat, val, w);
    model_step(1'b1, 8388608);
    n_total++; if (val !== model_out(m_phase, 200)) $display("FAIL dis_pre got %0d exp %0d", val, model_out(m_phase, 200)); else n_pass++;
    run_sample(1'b0, 24'd8388608, 14'd200, lat, val, w);
    model_step(1'b0, 0);
    n_total++; if (lat !== 0) $display("FAIL dis_latency got %0d exp 0", lat); else n_pass++;
    n_total++; if (val !== 0) $display("FAIL dis_val got %0d exp 0", val); else n_pass++;
    n_total++; if (w !== 1'b1) $display("FAIL dis_strobe_width got %b exp 1", w); else n_pass++;
    run_sample(1'b1, '0, 14'd50, lat, val, w);
    model_step(1'b1, 0);
    n_total++; if (val !== -50) $display("FAIL reen_val got %0d exp -50", val); else n_pass++;
  endtask

  task automatic test_random;
    int lat, val, exp_v, exp_lat; bit en, w;
    logic [AW-1:0] rate; logic [13:0] depth;
    for (int k = 0; k < 40; k++) begin
      en = ($urandom_range(0, 7) != 0);
      rate = AW'($urandom);
      depth = 14'($urandom);
      run_sample(en, rate, depth, lat, val, w);
      model_step(en, longint'(rate));
      exp_v = en ? model_out(m_phase, int'(depth)) : 0;
      exp_lat = en ? 16 : 0;
      n_total++; if (val !== exp_v || lat !== exp_lat)
        $display("FAIL rand[%0d] got %0d lat %0d exp %0d lat %0d", k, val, lat, exp_v, exp_lat);
      else n_pass++;
      idle_cycles($urandom_range(0, 6));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sequence();
    test_clamp();
    test_overrun();
    test_reset_midcalc();
    test_disable();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
